// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder
//   Instruction-memory responder. Accepts a fetch request with a 32-bit byte
//   address, waits WAIT_CYCLES cycles, then returns a big-endian 32-bit word
//   with a one-cycle valid pulse. Misaligned or out-of-range fetches are
//   rejected with a one-cycle error pulse one cycle after the request.
//   A byte-wide load port writes program memory in any state.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset (memory is not cleared)
//   req_i        fetch request, sampled only when not busy
//   addr_i       fetch byte address, captured with req_i
//   load_en_i    program-load byte write enable
//   load_addr_i  program-load byte address
//   load_byte_i  program-load data
//   instr_o      fetched word; holds until the next valid/err pulse
//   valid_o      one-cycle pulse, instr_o is a good response
//   err_o        one-cycle pulse, the fetch was rejected
//   busy_o       high while a fetch waits; new requests are ignored
module instr_fetch_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic [31:0]           addr_i,
    input  logic                  load_en_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [7:0]            load_byte_i,
    output logic [31:0]           instr_o,
    output logic                  valid_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           instr_q, instr_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] rd_a;
    logic                  bad_addr;

    logic [7:0] mem_q [0:DEPTH-1];

    // Misaligned, or any bit set above the implemented range (no wrap).
    assign bad_addr = (addr_i[1:0] != 2'b00) || (addr_i[31:ADDR_WIDTH] != '0);

    // Word address read on the edge that enters RESP: the freshly presented
    // address when jumping straight from IDLE/RESP (zero wait), else the
    // captured one.
    assign rd_a = (state_q == WAIT) ? addr_q : addr_i[ADDR_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                // RESP accepts a new request too, allowing back-to-back fetches.
                state_d = IDLE;
                if (req_i) begin
                    if (bad_addr) begin
                        err_d   = 1'b1;
                        instr_d = '0;
                    end else begin
                        addr_d = addr_i[ADDR_WIDTH-1:0];
                        if (WAIT_CYCLES == 0) begin
                            state_d = RESP;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        // Read uses the pre-edge memory contents, so a same-edge load to the
        // word returns the old byte.
        if (state_d == RESP) begin
            instr_d = {mem_q[{rd_a[ADDR_WIDTH-1:2], 2'b00}],
                       mem_q[{rd_a[ADDR_WIDTH-1:2], 2'b01}],
                       mem_q[{rd_a[ADDR_WIDTH-1:2], 2'b10}],
                       mem_q[{rd_a[ADDR_WIDTH-1:2], 2'b11}]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    // Program memory survives reset.
    always_ff @(posedge clk_i) begin
        if (load_en_i) mem_q[load_addr_i] <= load_byte_i;
    end

    assign instr_o = instr_q;
    assign valid_o = (state_q == RESP);
    assign err_o   = err_q;
    assign busy_o  = (state_q == WAIT);

endmodule

// File: tb/tb_instr_fetch_responder.sv
module tb_instr_fetch_responder;

    logic        clk = 1'b0;
    logic        reset, req, load_en;
    logic [31:0] addr;
    logic [7:0]  load_addr, load_byte;
    logic [31:0] instr;
    logic        valid, err, busy;

    int n_chk  = 0;
    int n_fail = 0;
    int vcount;

    instr_fetch_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (req),
        .addr_i      (addr),
        .load_en_i   (load_en),
        .load_addr_i (load_addr),
        .load_byte_i (load_byte),
        .instr_o     (instr),
        .valid_o     (valid),
        .err_o       (err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_byte = d;
        tick();
        load_en = 1'b0;
    endtask

    // Good fetch with WAIT_CYCLES=2: busy, busy, valid, then idle.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
        req = 1'b1; addr = a;
        tick();
        req = 1'b0;
        chk({tag, "_busy1"}, {31'b0, busy}, 32'd1);
        chk({tag, "_valid1"}, {31'b0, valid}, 32'd0);
        tick();
        chk({tag, "_busy2"}, {31'b0, busy}, 32'd1);
        tick();
        chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
        chk({tag, "_instr"}, instr, exp);
        chk({tag, "_busy3"}, {31'b0, busy}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        tick();
        chk({tag, "_vdrop"}, {31'b0, valid}, 32'd0);
        chk({tag, "_hold"}, instr, exp);
    endtask

    task automatic reject(input string tag, input logic [31:0] a);
        req = 1'b1; addr = a;
        tick();
        req = 1'b0;
        chk({tag, "_err"}, {31'b0, err}, 32'd1);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        tick();
        chk({tag, "_errdrop"}, {31'b0, err}, 32'd0);
        chk({tag, "_busy2"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; addr = '0;
        load_en = 1'b0; load_addr = '0; load_byte = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_err",   {31'b0, err},   32'd0);
        chk("rst_busy",  {31'b0, busy},  32'd0);

        load(8'h00, 8'h8C); load(8'h01, 8'h01); load(8'h02, 8'h00); load(8'h03, 8'h04);
        load(8'h04, 8'h20); load(8'h05, 8'h02); load(8'h06, 8'h00); load(8'h07, 8'h05);
        load(8'hFC, 8'hDE); load(8'hFD, 8'hAD); load(8'hFE, 8'hBE); load(8'hFF, 8'hEF);

        fetch("f0", 32'h0, 32'h8C010004);
        fetch("f4", 32'h4, 32'h20020005);

        reject("mis2",   32'h00000002);
        reject("oor100", 32'h00000100);
        reject("oorhi",  32'h80000000);

        fetch("top", 32'h000000FC, 32'hDEADBEEF);

        // Request held: second accept lands on the RESP cycle (back-to-back).
        vcount = 0;
        req = 1'b1; addr = 32'h0;
        tick(); if (valid) vcount++;
        addr = 32'h4;
        tick(); if (valid) vcount++;
        tick(); if (valid) vcount++;
        chk("b2b_first", instr, 32'h8C010004);
        tick(); if (valid) vcount++;
        chk("b2b_accept_busy", {31'b0, busy}, 32'd1);
        tick(); if (valid) vcount++;
        tick(); if (valid) vcount++;
        chk("b2b_second", instr, 32'h20020005);
        chk("b2b_count", vcount, 32'd2);
        req = 1'b0;
        tick();
        chk("b2b_idle", {31'b0, valid}, 32'd0);

        // Reset during WAIT aborts the fetch.
        req = 1'b1; addr = 32'h0;
        tick();
        req = 1'b0;
        chk("abort_busy_pre", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_instr", instr, 32'd0);
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (valid) vcount++;
            tick();
        end
        chk("abort_novalid", vcount, 32'd0);
        fetch("after_rst", 32'h0, 32'h8C010004);

        // Load on the edge entering RESP: read returns the old byte.
        req = 1'b1; addr = 32'h0;
        tick();
        req = 1'b0;
        tick();
        load_en = 1'b1; load_addr = 8'h03; load_byte = 8'hFF;
        tick();
        load_en = 1'b0;
        chk("rbw_valid", {31'b0, valid}, 32'd1);
        chk("rbw_instr", instr, 32'h8C010004);
        tick();
        fetch("refetch", 32'h0, 32'h8C0100FF);

        // Load during WAIT, before the read edge, is visible.
        req = 1'b1; addr = 32'h4;
        tick();
        req = 1'b0;
        load(8'h06, 8'h77);
        tick();
        chk("inflight_valid", {31'b0, valid}, 32'd1);
        chk("inflight_instr", instr, 32'h20027705);
        tick();

        // Reset and request on the same edge: request dropped.
        reset = 1'b1; req = 1'b1; addr = 32'h0;
        tick();
        reset = 1'b0; req = 1'b0;
        chk("rstreq_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("rstreq_busy2", {31'b0, busy}, 32'd0);
        tick();
        chk("rstreq_valid", {31'b0, valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
